cpu_fetch_queued: RTL and testbench

Parametrised instruction-fetch stage with a decoupled prefetch queue, placed between the instruction cache and the decode stage of the Rv32H pipeline. Fetches sequential words ahead of decode into a FIFO, tags each instruction, halts fetch after any control-transfer instruction until the pipeline resolves that branch by tag, and supports an asynchronous-to-flow redirect (trap/interrupt) that flushes the queue. Replaces the stall-based single-entry fetch with a valid/ready output handshake.

---
 rtl/cpu_fetch_queued_pkg.sv | 23 ++
 rtl/cpu_fetch_fifo.sv | 60 ++++++
 rtl/cpu_fetch_queued.sv | 131 +++++++++++++
 tb/tb_cpu_fetch_queued.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_queued_pkg.sv
// Shared fetch-stage definitions: control-transfer opcodes, the default tag width
// and the FSM state encoding.
package cpu_fetch_queued_pkg;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    localparam int DEFAULT_TAG_WIDTH = 8;

    typedef enum logic [0:0] {
        FETCH       = 1'b0,
        WAIT_BRANCH = 1'b1
    } fetch_state_e;

    // Fetch stops after any of these until execute resolves the target.
    function automatic logic is_control_transfer(input logic [31:0] instruction);
        return (instruction[6:0] == OPCODE_JAL) ||
               (instruction[6:0] == OPCODE_JALR) ||
               (instruction[6:0] == OPCODE_BRANCH);
    endfunction

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Prefetch FIFO: registered storage, head read straight from storage (no bypass),
// synchronous reset plus a flush that empties it and discards same-cycle push/pop.
module cpu_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 72,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LEVEL_W = PTR_W + 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               flush,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head,
    output logic [LEVEL_W-1:0] level,
    output logic               empty,
    output logic               full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LEVEL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge i_clock) begin
        if (i_reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; the top masks the head while the queue is empty.
    always_ff @(posedge i_clock) begin
        if (!i_reset && !flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/cpu_fetch_queued.sv
// Instruction fetch with a prefetch queue: fetches sequentially, tags each word,
// stalls after control transfers until resolved by tag, and flushes on redirect.
module cpu_fetch_queued
    import cpu_fetch_queued_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int QUEUE_DEPTH = 4,
    parameter int TAG_WIDTH = DEFAULT_TAG_WIDTH,
    localparam int LEVEL_W = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    output logic                 o_icache_request,
    output logic [31:0]          o_icache_pc,
    input  logic                 i_icache_ready,
    input  logic [31:0]          i_icache_rdata,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic [31:0]          i_pc_next,
    input  logic                 i_redirect,
    input  logic [31:0]          i_redirect_pc,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic [31:0]          o_instruction,
    output logic [31:0]          o_pc,
    output logic [LEVEL_W-1:0]   o_level,
    output fetch_state_e         o_state
);

    // Handshakes: a cache word transfers when o_icache_request && i_icache_ready;
    // a queue entry transfers to decode when o_valid && i_ready. Request and
    // o_valid never depend combinationally on i_ready.

    localparam int ENTRY_W = TAG_WIDTH + 64;

    fetch_state_e         state;
    fetch_state_e         state_next;
    logic [31:0]          pc;
    logic [TAG_WIDTH-1:0] tag_cnt;
    logic [TAG_WIDTH-1:0] tag_next;
    logic [TAG_WIDTH-1:0] branch_tag;
    logic                 push;
    logic                 pop;
    logic                 is_cti;
    logic                 branch_resolved;
    logic [ENTRY_W-1:0]   fifo_head;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [TAG_WIDTH-1:0] head_tag;
    logic [31:0]          head_instruction;
    logic [31:0]          head_pc;

    // Tag 0 is reserved so an idle (zero) i_tag can never resolve a branch.
    assign tag_next        = (tag_cnt == '1) ? TAG_WIDTH'(1) : tag_cnt + 1'b1;
    assign is_cti          = is_control_transfer(i_icache_rdata);
    assign branch_resolved = (i_tag == branch_tag);
    assign push            = o_icache_request && i_icache_ready && !i_redirect;
    assign pop             = o_valid && i_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (i_redirect) begin
            state_next = FETCH;
        end else begin
            case (state)
                FETCH:       if (push && is_cti) state_next = WAIT_BRANCH;
                WAIT_BRANCH: if (branch_resolved) state_next = FETCH;
                default:     state_next = FETCH;
            endcase
        end
    end

    // Held low during reset so the first request appears the cycle after release.
    always_comb begin
        o_icache_request = !i_reset && (state == FETCH) && !fifo_full;
    end

    // A word dropped by a redirect consumes no tag; the counter is never rewound.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc         <= RESET_VECTOR;
            tag_cnt    <= '0;
            branch_tag <= '0;
        end else if (i_redirect) begin
            pc <= i_redirect_pc;
        end else if (push) begin
            tag_cnt <= tag_next;
            if (is_cti) begin
                branch_tag <= tag_next;
            end else begin
                pc <= pc + 32'd4;
            end
        end else if (state == WAIT_BRANCH && branch_resolved) begin
            pc <= i_pc_next;
        end
    end

    cpu_fetch_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .flush     (i_redirect),
        .push      (push),
        .push_data ({tag_next, i_icache_rdata, pc}),
        .pop       (pop),
        .head      (fifo_head),
        .level     (o_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign {head_tag, head_instruction, head_pc} = fifo_head;

    assign o_icache_pc   = pc;
    assign o_valid       = !fifo_empty;
    assign o_tag         = o_valid ? head_tag : '0;
    assign o_instruction = o_valid ? head_instruction : '0;
    assign o_pc          = o_valid ? head_pc : '0;
    assign o_state       = state;

endmodule

// File: tb/tb_cpu_fetch_queued.sv
// Bench for cpu_fetch_queued: directed fetch scenarios on a depth-4/tag-8 instance
// and tag wrap on a tag-3 instance, checked by per-instance scoreboard monitors.
module tb_cpu_fetch_queued;
    import cpu_fetch_queued_pkg::*;

    localparam logic [31:0] JAL_WORD    = 32'h0000_006F;
    localparam logic [31:0] BRANCH_WORD = 32'h0000_0063;
    localparam logic [31:0] NO_CTI      = 32'h0000_0001;

    // ---------------- clock / reset ----------------
    logic i_clock = 1'b0;
    always #5 i_clock = ~i_clock;
    logic i_reset;

    // ---------------- main instance (tag width 8) ----------------
    logic        o_icache_request;
    logic [31:0] o_icache_pc;
    logic        i_icache_ready;
    logic [31:0] i_icache_rdata;
    logic [7:0]  i_tag;
    logic [31:0] i_pc_next;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_tag;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic [2:0]  o_level;
    fetch_state_e o_state;

    cpu_fetch_queued #(.RESET_VECTOR(32'h0), .QUEUE_DEPTH(4), .TAG_WIDTH(8)) u_dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .o_icache_request (o_icache_request),
        .o_icache_pc      (o_icache_pc),
        .i_icache_ready   (i_icache_ready),
        .i_icache_rdata   (i_icache_rdata),
        .i_tag            (i_tag),
        .i_pc_next        (i_pc_next),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_tag            (o_tag),
        .o_instruction    (o_instruction),
        .o_pc             (o_pc),
        .o_level          (o_level),
        .o_state          (o_state)
    );

    // ---------------- second instance (tag width 3) ----------------
    logic        req3;
    logic [31:0] ipc3;
    logic        cache_ready3;
    logic [31:0] rdata3;
    logic [2:0]  tag3_in;
    logic [31:0] pc_next3;
    logic        redirect3;
    logic        valid3;
    logic        dec_ready3;
    logic [2:0]  tag3_out;
    logic [31:0] instr3;
    logic [31:0] opc3;
    logic [2:0]  level3;
    fetch_state_e state3;

    cpu_fetch_queued #(.RESET_VECTOR(32'h0), .QUEUE_DEPTH(4), .TAG_WIDTH(3)) u_dut3 (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .o_icache_request (req3),
        .o_icache_pc      (ipc3),
        .i_icache_ready   (cache_ready3),
        .i_icache_rdata   (rdata3),
        .i_tag            (tag3_in),
        .i_pc_next        (pc_next3),
        .i_redirect       (redirect3),
        .i_redirect_pc    (32'h0),
        .o_valid          (valid3),
        .i_ready          (dec_ready3),
        .o_tag            (tag3_out),
        .o_instruction    (instr3),
        .o_pc             (opc3),
        .o_level          (level3),
        .o_state          (state3)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int budget   = 0;
    int budget3  = 0;
    logic [31:0] cti_addr  = NO_CTI;
    logic [31:0] cti_word  = JAL_WORD;
    logic [31:0] cti3_addr = NO_CTI;
    logic [31:0] cti3_word = BRANCH_WORD;
    logic [71:0] exp_q[$];
    logic [71:0] exp3_q[$];

    function automatic logic [31:0] alu_word(input logic [31:0] pc);
        return {pc[13:2], 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc, input logic [31:0] addr,
                                            input logic [31:0] word);
        return (pc == addr) ? word : alu_word(pc);
    endfunction

    function automatic logic [71:0] mk(input int tag, input logic [31:0] instr, input logic [31:0] pc);
        return {8'(tag), instr, pc};
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q.size() + exp3_q.size()) != 0 && n < limit) begin
            @(negedge i_clock);
            #1;
            n++;
        end
        check("drain", 72'(exp_q.size() + exp3_q.size()), 72'd0);
    endtask

    // ---------------- cache models: return up to budget words ----------------
    initial begin
        i_icache_ready = 1'b0;
        i_icache_rdata = '0;
        forever begin
            @(posedge i_clock);
            #2;
            i_icache_ready = (budget > 0);
            i_icache_rdata = word_at(o_icache_pc, cti_addr, cti_word);
        end
    end
    always @(negedge i_clock) if (o_icache_request && i_icache_ready) budget--;

    initial begin
        cache_ready3 = 1'b0;
        rdata3 = '0;
        forever begin
            @(posedge i_clock);
            #2;
            cache_ready3 = (budget3 > 0);
            rdata3 = word_at(ipc3, cti3_addr, cti3_word);
        end
    end
    always @(negedge i_clock) if (req3 && cache_ready3) budget3--;

    // ---------------- scoreboard monitors ----------------
    always @(negedge i_clock) begin : mon_main
        logic [71:0] e;
        if (!i_reset) begin
            if (o_valid && i_ready && !i_redirect) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got %h, expected none", {o_tag, o_instruction, o_pc});
                end else begin
                    e = exp_q.pop_front();
                    check("head_entry", {o_tag, o_instruction, o_pc}, e);
                end
            end
            if (!o_valid) check("idle_zero", {o_tag, o_instruction, o_pc}, 72'd0);
        end
    end

    always @(negedge i_clock) begin : mon_tag3
        logic [71:0] e;
        if (!i_reset && valid3 && dec_ready3) begin
            if (exp3_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out3: got %h, expected none", {tag3_out, instr3, opc3});
            end else begin
                e = exp3_q.pop_front();
                check("head_entry3", {5'd0, tag3_out, instr3, opc3}, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        i_reset = 1'b1;
        i_ready = 1'b0;
        i_tag = '0;
        i_pc_next = '0;
        i_redirect = 1'b0;
        i_redirect_pc = '0;
        tag3_in = '0;
        pc_next3 = '0;
        redirect3 = 1'b0;
        dec_ready3 = 1'b1;
        step();
        step();
        @(negedge i_clock);
        check("reset_ctl", {o_valid, o_icache_request, o_level}, 72'd0);
        check("reset_pc", {o_icache_pc, o_pc}, 72'd0);
        check("reset_state", o_state, FETCH);

        // Sequential stream of 8 ALU words, one per cycle.
        step();
        i_ready = 1'b1;
        budget = 8;
        for (int k = 0; k < 8; k++) exp_q.push_back(mk(k + 1, alu_word(32'(4 * k)), 32'(4 * k)));
        i_reset = 1'b0;
        @(negedge i_clock);
        check("first_cycle", {o_valid, o_icache_request}, 72'b01);
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clock);
            check("stream_pc", {o_valid, o_pc}, {1'b1, 32'(4 * k)});
        end
        wait_drain(10);

        // Decode stalled: queue fills to 4 then request drops.
        step();
        i_ready = 1'b0;
        budget = 6;
        for (int k = 0; k < 6; k++) exp_q.push_back(mk(9 + k, alu_word(32'h20 + 32'(4 * k)), 32'h20 + 32'(4 * k)));
        repeat (8) step();
        @(negedge i_clock);
        check("full_level", o_level, 72'd4);
        check("full_req", o_icache_request, 72'd0);
        check("full_accepted", 72'(budget), 72'd2);
        step();
        i_ready = 1'b1;
        @(negedge i_clock);
        check("full_pop_req", o_icache_request, 72'd0);
        step();
        @(negedge i_clock);
        check("resume_req", o_icache_request, 72'd1);
        wait_drain(20);

        // JAL at 0x10 waits for its tag, then fetch resumes at the target.
        step();
        i_reset = 1'b1;
        cti_addr = 32'h10;
        cti_word = JAL_WORD;
        step();
        step();
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(k + 1, alu_word(32'(4 * k)), 32'(4 * k)));
        exp_q.push_back(mk(5, JAL_WORD, 32'h10));
        budget = 5;
        i_reset = 1'b0;
        wait_drain(20);
        @(negedge i_clock);
        check("jal_wait_req", o_icache_request, 72'd0);
        check("jal_wait_state", o_state, WAIT_BRANCH);
        step();
        budget = 1;
        i_tag = 8'd4;
        i_pc_next = 32'h100;
        repeat (3) step();
        @(negedge i_clock);
        check("wrong_tag_req", o_icache_request, 72'd0);
        step();
        i_tag = 8'd5;
        i_pc_next = 32'h200;
        exp_q.push_back(mk(6, alu_word(32'h200), 32'h200));
        @(negedge i_clock);
        check("match_cycle_req", o_icache_request, 72'd0);
        step();
        @(negedge i_clock);
        check("branch_target", {o_icache_request, o_icache_pc}, {1'b1, 32'h200});
        wait_drain(10);
        step();
        i_tag = '0;
        cti_addr = NO_CTI;

        // Redirect with 3 queued entries while the cache returns a word.
        i_ready = 1'b0;
        budget = 3;
        repeat (5) step();
        @(negedge i_clock);
        check("pre_redirect", {o_level, o_icache_request}, {3'd3, 1'b1});
        step();
        i_redirect = 1'b1;
        i_redirect_pc = 32'h80;
        i_ready = 1'b1;
        budget = 1;
        @(negedge i_clock);
        check("redirect_word_offered", {o_icache_request, i_icache_ready}, 72'b11);
        step();
        i_redirect = 1'b0;
        @(negedge i_clock);
        check("post_redirect_q", {o_valid, o_level}, 72'd0);
        check("post_redirect_req", {o_icache_request, o_icache_pc}, {1'b1, 32'h80});
        step();
        exp_q.push_back(mk(10, alu_word(32'h80), 32'h80));
        exp_q.push_back(mk(11, alu_word(32'h84), 32'h84));
        budget = 2;
        wait_drain(10);

        // Push and pop together at level 2, then PC wraps past 0xFFFFFFFC.
        step();
        i_ready = 1'b0;
        i_redirect = 1'b1;
        i_redirect_pc = 32'hFFFF_FFF4;
        step();
        i_redirect = 1'b0;
        exp_q.push_back(mk(12, alu_word(32'hFFFF_FFF4), 32'hFFFF_FFF4));
        exp_q.push_back(mk(13, alu_word(32'hFFFF_FFF8), 32'hFFFF_FFF8));
        exp_q.push_back(mk(14, alu_word(32'hFFFF_FFFC), 32'hFFFF_FFFC));
        exp_q.push_back(mk(15, alu_word(32'h0), 32'h0));
        budget = 2;
        repeat (4) step();
        @(negedge i_clock);
        check("level_two", o_level, 72'd2);
        step();
        i_ready = 1'b1;
        budget = 1;
        step();
        i_ready = 1'b0;
        @(negedge i_clock);
        check("push_pop_level", o_level, 72'd2);
        check("pc_wrap", {o_icache_request, o_icache_pc}, {1'b1, 32'h0});
        step();
        budget = 1;
        i_ready = 1'b1;
        wait_drain(10);

        // Reset while a cache word is on offer.
        step();
        i_ready = 1'b0;
        budget = 2;
        step();
        i_reset = 1'b1;
        @(negedge i_clock);
        check("reset_req_low", o_icache_request, 72'd0);
        step();
        @(negedge i_clock);
        check("midreset_ctl", {o_valid, o_icache_request, o_level}, 72'd0);
        check("midreset_pc", {o_icache_pc, o_pc}, 72'd0);
        budget = 0;

        // Tag width 3: tags 1..7 then wrap to 1 (0 skipped); branch on tag 1 waits.
        cti3_addr = 32'h1C;
        cti3_word = BRANCH_WORD;
        for (int k = 0; k < 7; k++) exp3_q.push_back(mk(k + 1, alu_word(32'(4 * k)), 32'(4 * k)));
        exp3_q.push_back(mk(1, BRANCH_WORD, 32'h1C));
        budget3 = 8;
        step();
        i_reset = 1'b0;
        wait_drain(20);
        step();
        budget3 = 1;
        repeat (3) step();
        @(negedge i_clock);
        check("tag3_wait", {req3, state3}, {1'b0, WAIT_BRANCH});
        step();
        tag3_in = 3'd1;
        pc_next3 = 32'h40;
        exp3_q.push_back(mk(2, alu_word(32'h40), 32'h40));
        wait_drain(10);
        step();
        check("tag3_level", level3, 72'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
